// File: rtl/ascon_init.sv
// Ascon-128a initialization: loads IV||K||N, runs p^a and XORs K into x3||x4.
// Build option ASCON_INIT_UNROLL2_EN: two cascaded rounds per clock edge.
module ascon_init #(
  parameter logic [63:0] IV        = 64'h80800c0800000000,
  parameter int          PA_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  output logic         busy,
  output logic         done,
  output logic [319:0] ini_sout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef ASCON_INIT_UNROLL2_EN
  localparam int RND_STEP = 2;
`else
  localparam int RND_STEP = 1;
`endif
  localparam logic [3:0] RND_FIRST = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] RND_LAST  = 4'(12 - RND_STEP);

  if (PA_ROUNDS < 1 || PA_ROUNDS > 12) begin : g_bad_rounds
    $error("ascon_init: PA_ROUNDS must be in 1..12");
  end
  if ((PA_ROUNDS % RND_STEP) != 0) begin : g_bad_unroll
    $error("ascon_init: PA_ROUNDS must be even in the unrolled build");
  end

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full Ascon round: constant addition, bit-sliced S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c = 8'hf0 - 8'(r) * 8'h0f;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, c};
    // NOTE: blocking assignments are correct here; this is a combinational
    // function evaluated top-to-bottom, not clocked state.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = x0 ^ (~x1 & x2);
    t1 = x1 ^ (~x2 & x3);
    t2 = x2 ^ (~x3 & x4);
    t3 = x3 ^ (~x4 & x0);
    t4 = x4 ^ (~x0 & x1);
    t1 = t1 ^ t0;
    t0 = t0 ^ t4;
    t3 = t3 ^ t2;
    t2 = ~t2;
    x0 = t0 ^ rotr(t0, 19) ^ rotr(t0, 28);
    x1 = t1 ^ rotr(t1, 61) ^ rotr(t1, 39);
    x2 = t2 ^ rotr(t2, 1)  ^ rotr(t2, 6);
    x3 = t3 ^ rotr(t3, 10) ^ rotr(t3, 17);
    x4 = t4 ^ rotr(t4, 7)  ^ rotr(t4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [319:0]   s_q, s_d;
  logic [127:0]   key_q, key_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [319:0]   sout_q, sout_d;
  logic [319:0]   round_out;

`ifdef ASCON_INIT_UNROLL2_EN
  assign round_out = ascon_round(ascon_round(s_q, rnd_q), 4'(rnd_q + 4'd1));
`else
  assign round_out = ascon_round(s_q, rnd_q);
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sout_d  = sout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = {IV, key, nonce};
          key_d   = key;
          rnd_d   = RND_FIRST;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = round_out;
        rnd_d = 4'(rnd_q + 4'(RND_STEP));
        if (rnd_q == RND_LAST) begin
          sout_d  = round_out ^ {192'h0, key_q};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      s_q     <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sout_q  <= sout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ini_sout = sout_q;

endmodule

// File: tb/tb_ascon_init.sv
// Scoreboard bench for ascon_init: a column-wise reference permutation predicts
// ini_sout at each accepted start; results are compared when done pulses.
module tb_ascon_init;

  localparam logic [63:0] IV        = 64'h80800c0800000000;
  localparam int          PA_ROUNDS = 12;
`ifdef ASCON_INIT_UNROLL2_EN
  localparam int LAT = PA_ROUNDS / 2;
`else
  localparam int LAT = PA_ROUNDS;
`endif

  typedef struct {
    logic [319:0] sout;
    logic [319:0] pre;
    logic [127:0] key;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] nonce;
  logic         busy;
  logic         done;
  logic [319:0] ini_sout;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [319:0] last_sout = '0;

  ascon_init dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .nonce    (nonce),
    .busy     (busy),
    .done     (done),
    .ini_sout (ini_sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference S-box on a single 5-bit column, x0 as the MSB.
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    logic a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
    {a0, a1, a2, a3, a4} = v;
    a0 ^= a4; a4 ^= a3; a2 ^= a1;
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    b1 ^= b0; b0 ^= b4; b3 ^= b2; b2 = ~b2;
    return {b0, b1, b2, b3, b4};
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s_in);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  col;
    for (int i = 0; i < 5; i++) x[i] = s_in[319 - 64*i -: 64];
    for (int r = 12 - PA_ROUNDS; r < 12; r++) begin
      x[2] ^= 64'(240 - 15 * r);
      for (int j = 0; j < 64; j++) begin
        col = sbox5({x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]});
        for (int i = 0; i < 5; i++) y[i][j] = col[4 - i];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Drives a one-cycle start that the DUT accepts, and predicts its result.
  task automatic do_start(input logic [127:0] k, input logic [127:0] n);
    exp_t e;
    e.pre  = perm({IV, k, n});
    e.key  = k;
    e.sout = e.pre ^ {192'h0, k};
    exp_q.push_back(e);
    key   = k;
    nonce = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_accept", 320'(busy), 320'd1);
    check("done_after_accept", 320'(done), 320'd0);
  endtask

  // Waits for done; optionally pulses start with another key at two cycles.
  task automatic wait_done(input string tag, input int inj_a, input int inj_b,
                           input logic [127:0] alt);
    int   n      = 0;
    int   busy_n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 200) begin
      if (n == inj_a || n == inj_b) begin
        start = 1'b1;
        key   = alt;
        nonce = ~alt;
      end
      tick();
      start = 1'b0;
      n++;
      if (busy === 1'b1) busy_n++;
    end
    check({tag, "_latency"}, 320'(n), 320'(LAT));
    check({tag, "_busy_cycles"}, 320'(busy_n), 320'(LAT - 1));
    check({tag, "_busy_at_done"}, 320'(busy), 320'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_sout"}, ini_sout, e.sout);
      check({tag, "_x34"}, 320'(ini_sout[127:0]), 320'(e.pre[127:0] ^ e.key));
      last_sout = e.sout;
    end
  endtask

  initial begin
    logic [127:0] k1, k2, k3;
    int           dn;
    k1    = 128'h000102030405060708090A0B0C0D0E0F;
    k2    = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    k3    = 128'h0F0E0D0C0B0A09080706050403020100;
    rst   = 1'b0;
    start = 1'b0;
    key   = '0;
    nonce = '0;

    repeat (3) tick();
    check("reset_busy", 320'(busy), 320'd0);
    check("reset_done", 320'(done), 320'd0);
    check("reset_sout", ini_sout, 320'h0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", 320'(busy), 320'd0);
      check("idle_done", 320'(done), 320'd0);
      check("idle_sout", ini_sout, 320'h0);
    end

    do_start(k1, k1);
    wait_done("basic", -1, -1, '0);
    tick();
    check("done_pulse_width", 320'(done), 320'd0);
    check("sout_hold", ini_sout, last_sout);

    do_start('0, '0);
    wait_done("zero", -1, -1, '0);
    check("zero_no_key_effect", ini_sout, perm({IV, 256'h0}));
    tick();

    // Starts during the run are ignored; a start in the done cycle is taken.
    do_start(k3, k1);
    wait_done("ignored", 2, 6, k2);
    do_start(k2, k3);
    check("hold_through_accept", ini_sout, last_sout);
    wait_done("b2b", -1, -1, '0);
    tick();

    do_start(k2, k1);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 320'(busy), 320'd0);
    check("abort_done", 320'(done), 320'd0);
    check("abort_sout", ini_sout, 320'h0);
    void'(exp_q.pop_back());
    repeat (2) tick();
    rst = 1'b1;
    dn  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    check("abort_no_done", 320'(dn), 320'd0);
    do_start(k1, k1);
    wait_done("after_abort", -1, -1, '0);
    tick();

    check("scoreboard_empty", 320'(exp_q.size()), 320'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
